// File: rtl/vedacao_garrafa_if.sv
// Station-side signal bundle for the bottle capping controller.
// The line and cork-counter side drives the master modport; the controller takes the slave modport.
interface vedacao_garrafa_if;
    logic       enable;
    logic       garrafa_presente;
    logic       rolha_disponivel;
    logic       alarme;
    logic       dec;
    logic       motor_esteira;
    logic       atuador_vedacao;
    logic       garrafa_vedada;
    logic       erro_sem_rolha;
    logic [7:0] vedadas;
    logic [2:0] estado;

    modport master (
        output enable, garrafa_presente, rolha_disponivel, alarme,
        input  dec, motor_esteira, atuador_vedacao, garrafa_vedada,
        input  erro_sem_rolha, vedadas, estado
    );

    modport slave (
        input  enable, garrafa_presente, rolha_disponivel, alarme,
        output dec, motor_esteira, atuador_vedacao, garrafa_vedada,
        output erro_sem_rolha, vedadas, estado
    );
endinterface

// File: rtl/vedacao_garrafa.sv
// Bottle capping station controller: advances a bottle, requests a cork, presses the cap and
// releases the bottle, parking in an error state while no cork is available.
module vedacao_garrafa #(
    parameter int T_VEDA   = 4,
    parameter int T_ESPERA = 8
) (
    input  logic               clk,
    input  logic               reset,
    vedacao_garrafa_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        AVANCA     = 3'd1,
        PEDE_ROLHA = 3'd2,
        VEDA       = 3'd3,
        LIBERA     = 3'd4,
        ERRO       = 3'd5
    } estado_t;

    localparam logic [3:0] VEDA_LAST   = 4'(T_VEDA - 1);
    localparam logic [3:0] ESPERA_LAST = 4'(T_ESPERA - 1);

    estado_t    state_q;
    logic [3:0] timer_q;
    logic       dec_q;
    logic       vedada_q;
    logic [7:0] vedadas_q;

    // The timer is shared: cork wait in PEDE_ROLHA, press duration in VEDA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= 4'd0;
            dec_q     <= 1'b0;
            vedada_q  <= 1'b0;
            vedadas_q <= 8'd0;
        end else begin
            dec_q    <= 1'b0;
            vedada_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.enable) state_q <= AVANCA;
                end
                AVANCA: begin
                    if (bus.garrafa_presente) begin
                        state_q <= PEDE_ROLHA;
                        timer_q <= 4'd0;
                    end else if (!bus.enable) begin
                        state_q <= IDLE;
                    end
                end
                PEDE_ROLHA: begin
                    if (bus.alarme) begin
                        state_q <= ERRO;
                    end else if (bus.rolha_disponivel) begin
                        dec_q   <= 1'b1;
                        state_q <= VEDA;
                        timer_q <= 4'd0;
                    end else if (timer_q == ESPERA_LAST) begin
                        state_q <= ERRO;
                    end else begin
                        timer_q <= timer_q + 4'd1;
                    end
                end
                VEDA: begin
                    if (timer_q == VEDA_LAST) state_q <= LIBERA;
                    else                      timer_q <= timer_q + 4'd1;
                end
                LIBERA: begin
                    if (!bus.garrafa_presente) begin
                        state_q   <= bus.enable ? AVANCA : IDLE;
                        vedada_q  <= 1'b1;
                        vedadas_q <= vedadas_q + 8'd1;
                    end
                end
                ERRO: begin
                    if (bus.rolha_disponivel && !bus.alarme) begin
                        state_q <= PEDE_ROLHA;
                        timer_q <= 4'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Drives decode straight from the state register so reset removes them without waiting for an edge.
    assign bus.motor_esteira   = (state_q == AVANCA) || (state_q == LIBERA);
    assign bus.atuador_vedacao = (state_q == VEDA);
    assign bus.erro_sem_rolha  = (state_q == ERRO);
    assign bus.dec             = dec_q;
    assign bus.garrafa_vedada  = vedada_q;
    assign bus.vedadas         = vedadas_q;
    assign bus.estado          = state_q;

endmodule

// File: doc/vedacao_garrafa.md
VEDACAO_GARRAFA -- requirements
Module: vedacao_garrafa

Parameters
REQ-001 The block SHALL have parameter T_VEDA, default 4: number of cycles the capping actuator stays asserted (1..15).
REQ-002 The block SHALL have parameter T_ESPERA, default 8: number of cycles it waits for a cork before flagging an error (1..15).

Interface
REQ-003 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-005 enable  input  1  line run command; high allows a new bottle cycle to start.
REQ-006 garrafa_presente  input  1  bottle sensor at the capping station; high while a bottle is in position.
REQ-007 rolha_disponivel  input  1  from the cork counter; high while the count is greater than 0.
REQ-008 alarme  input  1  from the cork counter; high when both the count and the stock are 0.
REQ-009 dec  output  1  cork-consume request to the cork counter; exactly one-cycle pulse per capped bottle.
REQ-010 motor_esteira  output  1  conveyor drive.
REQ-011 atuador_vedacao  output  1  capping press drive.
REQ-012 garrafa_vedada  output  1  one-cycle pulse when a bottle leaves the station capped.
REQ-013 erro_sem_rolha  output  1  high while in state ERRO.
REQ-014 vedadas  output  8  running count of capped bottles.
REQ-015 estado  output  3  current state encoding, for debug.

Function
REQ-016 The FSM SHALL have these states and encodings: IDLE=0, AVANCA=1, PEDE_ROLHA=2, VEDA=3, LIBERA=4, ERRO=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-017 IDLE: enable=1 SHALL go to AVANCA; otherwise the FSM SHALL stay in IDLE.
REQ-018 AVANCA: motor_esteira=1.
  - garrafa_presente=1 SHALL go to PEDE_ROLHA and clear the timer.
  - enable=0 with no bottle present SHALL go to IDLE; the bottle check takes priority over the enable check.
REQ-019 PEDE_ROLHA: motor_esteira=0.
  - alarme=1 SHALL go to ERRO; this takes priority over every other condition.
  - rolha_disponivel=1 SHALL assert dec for exactly this cycle, go to VEDA and clear the timer.
  - otherwise the timer SHALL increment; timer reaching T_ESPERA-1 without a cork SHALL go to ERRO.
REQ-020 dec SHALL be registered and SHALL be high for exactly the one cycle following the PEDE_ROLHA->VEDA decision edge.
REQ-021 dec SHALL NOT be asserted in any other state and SHALL NOT be asserted twice for the same bottle.
REQ-022 VEDA: atuador_vedacao=1 for exactly T_VEDA consecutive cycles, then the FSM SHALL go to LIBERA.
REQ-023 LIBERA: motor_esteira=1.
  - garrafa_presente=0 SHALL go to AVANCA if enable=1, else to IDLE.
  - The same edge SHALL pulse garrafa_vedada and increment vedadas by 1.
REQ-024 vedadas SHALL be an 8-bit counter that wraps from 255 to 0 with no flag.
REQ-025 ERRO: motor_esteira=0, atuador_vedacao=0, erro_sem_rolha=1.
  - Exit SHALL occur when rolha_disponivel=1 and alarme=0, going to PEDE_ROLHA with the timer cleared.
  - The bottle SHALL then be capped normally.
REQ-026 garrafa_presente falling while in PEDE_ROLHA, VEDA or ERRO SHALL be ignored; the sequence always completes for a bottle once it has been detected.
REQ-027 enable=0 SHALL only take effect in IDLE, AVANCA and LIBERA; an in-progress cap is never aborted.
REQ-028 motor_esteira and atuador_vedacao SHALL never both be 1; they are decoded from the registered state.
REQ-029 All inputs SHALL be treated as synchronous to clk; input synchronizers are out of scope.

Reset
REQ-030 While reset=0, the block SHALL hold: state=IDLE, timer=0, dec=0, garrafa_vedada=0, vedadas=0, and all drive outputs at 0.
REQ-031 Reset asserted mid-operation, including during VEDA with dec or the actuator high, SHALL drop all outputs within the same cycle.
REQ-032 After reset releases, operation SHALL resume from IDLE on the first rising clk edge.

Verification
REQ-033 Normal cycle: enable=1; bottle arrives at cycle 3; rolha_disponivel=1.
  - Expected: dec high for 1 cycle, atuador_vedacao high for 4 cycles, garrafa_vedada pulse on bottle removal, vedadas=1.
REQ-034 Late cork: rolha_disponivel=0 for 5 cycles after the bottle arrives, then 1.
  - Expected: no ERRO, exactly one dec, cap completes.
REQ-035 Timeout and recovery: rolha_disponivel held at 0.
  - Expected: ERRO entered after 8 cycles in PEDE_ROLHA with erro_sem_rolha=1.
  - Then rolha_disponivel=1: PEDE_ROLHA, one dec, VEDA.
REQ-036 Alarm priority: alarme=1 and rolha_disponivel=1 in PEDE_ROLHA.
  - Expected: ERRO, no dec.
REQ-037 Wrap: 256 consecutive bottles.
  - Expected: vedadas returns to 0 and 256 dec pulses are counted.
REQ-038 Reset mid-VEDA: reset=0 at the 2nd actuator cycle.
  - Expected: all outputs 0 immediately, estado=0, vedadas=0, and a normal cycle succeeds after release.
